// File: rtl/pc_pkg.sv
// Shared PC-core definitions: interrupt-acknowledge state encoding and widths.
package pc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CTR_W   = 3;
  localparam int unsigned DATA_W  = 8;

  localparam logic [DATA_W-1:0] NMI_VECTOR = 8'h02;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 4'd0,
    A1_T1 = 4'd1,
    A1_T2 = 4'd2,
    A1_T3 = 4'd3,
    A1_TW = 4'd4,
    A1_T4 = 4'd5,
    GAP   = 4'd6,
    A2_T1 = 4'd7,
    A2_T2 = 4'd8,
    A2_T3 = 4'd9,
    A2_TW = 4'd10,
    A2_T4 = 4'd11,
    DONE  = 4'd12
  } intack_state_t;

endpackage

// File: rtl/intack_wait_ctr.sv
// Loadable down-counter with zero flag, shared by the TW and GAP states.
module intack_wait_ctr
  import pc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CTR_W-1:0] count;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CTR_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/intack_sequencer.sv
// CPU-side interrupt-acknowledge initiator: runs the two-pulse INTA bus
// sequence, captures the PIC vector and hands it over a valid/ack handshake.
// Optional feature: define INTACK_NMI_EN to add the nmi input and the
// non-maskable fast path (IDLE -> DONE with NMI_VECTOR, no bus cycles).
module intack_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intr,
  input  logic              if_flag,
  input  logic              insn_boundary,
  input  logic [DATA_W-1:0] d_in,
  output logic              inta_n,
  output logic              lock_n,
  output logic              busy,
  output logic [DATA_W-1:0] vector,
  output logic              vec_valid,
`ifdef INTACK_NMI_EN
  input  logic              nmi,
`endif
  input  logic              vec_ack
);

  // Counter reload values: the counter reaches zero on the last clock of the state.
  localparam logic [CTR_W-1:0] TW_LOAD  = CTR_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam logic [CTR_W-1:0] GAP_LOAD = CTR_W'(GAP_CYCLES - 1);

  intack_state_t    state_q, state_d;
  logic             ctr_load, ctr_dec, ctr_zero_c;
  logic [CTR_W-1:0] ctr_load_val;
  logic             capture, nmi_take;
  logic             inta_n_d, lock_n_d, busy_d, vec_valid_d;

  intack_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .dec      (ctr_dec),
    .zero_c   (ctr_zero_c)
  );

`ifdef INTACK_NMI_EN
  logic nmi_q, nmi_pend_q;

  // Latch rising edges of nmi; cleared on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_q      <= nmi;
      nmi_pend_q <= (nmi & ~nmi_q) |
                    (nmi_pend_q & ~((state_d == DONE) && (state_q != DONE)));
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, counter control and next-output decode.
  always_comb begin
    state_d      = state_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_dec      = 1'b0;
    capture      = 1'b0;
    nmi_take     = 1'b0;

    case (state_q)
      IDLE: begin
`ifdef INTACK_NMI_EN
        if (nmi_pend_q && insn_boundary) begin
          state_d  = DONE;
          nmi_take = 1'b1;
        end else if (intr && if_flag && insn_boundary) begin
          state_d = A1_T1;
        end
`else
        if (intr && if_flag && insn_boundary) state_d = A1_T1;
`endif
      end
      A1_T1: state_d = A1_T2;
      A1_T2: state_d = A1_T3;
      A1_T3: begin
        if (WAIT_STATES == 0) begin
          state_d = A1_T4;
        end else begin
          state_d      = A1_TW;
          ctr_load     = 1'b1;
          ctr_load_val = TW_LOAD;
        end
      end
      A1_TW: begin
        if (ctr_zero_c) state_d = A1_T4;
        else            ctr_dec = 1'b1;
      end
      A1_T4: begin
        state_d      = GAP;
        ctr_load     = 1'b1;
        ctr_load_val = GAP_LOAD;
      end
      GAP: begin
        if (ctr_zero_c) state_d = A2_T1;
        else            ctr_dec = 1'b1;
      end
      A2_T1: state_d = A2_T2;
      A2_T2: state_d = A2_T3;
      A2_T3: begin
        if (WAIT_STATES == 0) begin
          state_d = A2_T4;
          capture = 1'b1;
        end else begin
          state_d      = A2_TW;
          ctr_load     = 1'b1;
          ctr_load_val = TW_LOAD;
        end
      end
      A2_TW: begin
        if (ctr_zero_c) begin
          state_d = A2_T4;
          capture = 1'b1;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      A2_T4: state_d = DONE;
      DONE: begin
        if (vec_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registers line up with it.
    inta_n_d    = 1'b1;
    lock_n_d    = 1'b1;
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    vec_valid_d = (state_d == DONE);

    case (state_d)
      A1_T2, A1_T3, A1_TW, A2_T2, A2_T3, A2_TW: inta_n_d = 1'b0;
      default: ;
    endcase

    case (state_d)
      A1_T2, A1_T3, A1_TW, A1_T4, GAP, A2_T1, A2_T2: lock_n_d = 1'b0;
      default: ;
    endcase
  end

  // Registered bus strobes and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inta_n    <= 1'b1;
      lock_n    <= 1'b1;
      busy      <= 1'b0;
      vec_valid <= 1'b0;
    end else begin
      inta_n    <= inta_n_d;
      lock_n    <= lock_n_d;
      busy      <= busy_d;
      vec_valid <= vec_valid_d;
    end
  end

  // Vector register: PIC byte on the closing edge of the second pulse, or NMI vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vector <= '0;
    end else if (capture) begin
      vector <= d_in;
    end else if (nmi_take) begin
      vector <= NMI_VECTOR;
    end
  end

endmodule
